apb_slave_regfile: RTL

- APB completer (slave) that terminates transfers from the team's APB initiator through the `apb_if` signal set.
- Implements a small 32-bit register file with byte-strobe writes, a read-only ID word, programmable wait-state insertion and PSLVERR on illegal accesses.
- Sits behind the APB bus as the device under test for the initiator. It is also the responder that makes PREADY rise during every access phase.

---
 rtl/apb_slave_regfile.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/apb_slave_regfile.sv
// APB completer fronting a small 32-bit register file (word 0 = read-only ID).
// Latency: setup + WAIT_STATES+1 access cycles; PREADY is decoded from registered state only.
// Backpressure: PREADY is held low for WAIT_STATES access cycles; PSLVERR flags illegal accesses.
module apb_slave_regfile #(
   parameter int                   ADDR_WIDTH  = 32,
   parameter int                   DATA_WIDTH  = 32,
   parameter int                   NUM_REGS    = 16,
   parameter int                   WAIT_STATES = 0,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA0B0_0001
) (
   input  logic                      PCLK,
   input  logic                      RESET,
   input  logic [ADDR_WIDTH-1:0]     PADDR,
   input  logic                      PSEL,
   input  logic                      PENABLE,
   input  logic                      PWRITE,
   input  logic [DATA_WIDTH-1:0]     PWDATA,
   input  logic [DATA_WIDTH/8-1:0]   PSTRB,
   output logic [DATA_WIDTH-1:0]     PRDATA,
   output logic                      PREADY,
   output logic                      PSLVERR
);

   localparam int STRB_WIDTH = DATA_WIDTH / 8;
   localparam int IDX_WIDTH  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int WIDX_WIDTH = ADDR_WIDTH - 2;

   // Register count expressed at word-address width so the range test is width-matched.
   localparam logic [WIDX_WIDTH-1:0] NUM_REGS_W = WIDX_WIDTH'(NUM_REGS);
   localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

   typedef enum logic {
      ST_IDLE,
      ST_ACCESS
   } state_t;

   // Everything about a transfer that must survive from setup to completion.
   typedef struct packed {
      logic [IDX_WIDTH-1:0]  idx;
      logic                  write;
      logic                  err;
      logic [DATA_WIDTH-1:0] wdata;
      logic [STRB_WIDTH-1:0] strb;
   } req_t;

   state_t                state_q;
   state_t                state_nxt;
   logic [3:0]            cnt_q;
   logic [3:0]            cnt_nxt;
   req_t                  req_q;
   req_t                  setup_req;
   logic [WIDX_WIDTH-1:0] setup_widx;
   logic [DATA_WIDTH-1:0] setup_rdata;
   logic [DATA_WIDTH-1:0] prdata_q;
   logic                  capture;
   logic                  complete;
   logic                  abort;
   logic                  ready;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   // Decode the bus request presented in the setup phase: index, error class and read value.
   always_comb begin
      setup_widx      = PADDR[ADDR_WIDTH-1:2];
      setup_req.idx   = setup_widx[IDX_WIDTH-1:0];
      setup_req.write = PWRITE;
      setup_req.wdata = PWDATA;
      setup_req.strb  = PSTRB;
      setup_req.err   = (PADDR[1:0] != 2'b00)
                      || (setup_widx >= NUM_REGS_W)
                      || (PWRITE && (setup_widx == '0));
      setup_rdata     = '0;
      if (!PWRITE && !setup_req.err) begin
         if (setup_req.idx == '0) begin
            setup_rdata = ID_VALUE;
         end else begin
            setup_rdata = regs[setup_req.idx];
         end
      end
   end

   // State and wait-counter registers.
   always_ff @(posedge PCLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
      end
   end

   // Next-state logic: setup capture, wait countdown, completion and abort.
   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      capture   = 1'b0;
      complete  = 1'b0;
      abort     = 1'b0;
      ready     = (state_q == ST_ACCESS) && (cnt_q == '0);
      case (state_q)
         ST_IDLE: begin
            // PSEL with PENABLE already high is a protocol violation and is ignored.
            if (PSEL && !PENABLE) begin
               state_nxt = ST_ACCESS;
               cnt_nxt   = WAIT_INIT;
               capture   = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (!PSEL) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               abort     = 1'b1;
            end else if (ready && PENABLE) begin
               state_nxt = ST_IDLE;
               complete  = 1'b1;
            end else if (cnt_q != '0) begin
               cnt_nxt = cnt_q - 4'd1;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Capture the request at setup; read data is loaded early so it is valid with PREADY.
   always_ff @(posedge PCLK) begin
      if (RESET) begin
         req_q    <= '0;
         prdata_q <= '0;
      end else if (capture) begin
         req_q    <= setup_req;
         prdata_q <= setup_rdata;
      end else if (complete || abort) begin
         prdata_q <= '0;
      end
   end

   // Register file: byte-strobed writes commit only at an error-free completion.
   always_ff @(posedge PCLK) begin
      if (RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (complete && req_q.write && !req_q.err) begin
         for (int b = 0; b < STRB_WIDTH; b++) begin
            if (req_q.strb[b]) begin
               regs[req_q.idx][b*8 +: 8] <= req_q.wdata[b*8 +: 8];
            end
         end
      end
   end

   assign PREADY  = ready;
   assign PSLVERR = ready && req_q.err;
   assign PRDATA  = prdata_q;

endmodule
